// File: rtl/fpu_ss_inflight_tracker_if.sv
// Bus bundle for the in-flight tracker: allocation, completion lookup, hazard query and occupancy.
// The tracker takes the slave side; the issue/writeback logic takes the master side.
interface fpu_ss_inflight_tracker_if #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned AddrWidth  = 5,
  parameter int unsigned NumRsPorts = 3
);
  localparam int unsigned CntW = $clog2(NumEntries + 1);

  logic                            flush_i;
  logic                            alloc_valid_i;
  logic                            alloc_ready_o;
  logic [IdWidth-1:0]              alloc_id_i;
  logic [AddrWidth-1:0]            alloc_addr_i;
  logic                            alloc_rd_is_fp_i;
  logic                            alloc_we_i;
  logic [NumRsPorts*AddrWidth-1:0] rs_addr_i;
  logic [NumRsPorts-1:0]           rs_is_fp_i;
  logic [NumRsPorts-1:0]           rs_busy_o;
  logic                            cmpl_valid_i;
  logic [IdWidth-1:0]              cmpl_id_i;
  logic                            cmpl_hit_o;
  logic [AddrWidth-1:0]            cmpl_addr_o;
  logic                            cmpl_rd_is_fp_o;
  logic                            cmpl_we_o;
  logic                            cmpl_err_o;
  logic [CntW-1:0]                 count_o;
  logic                            empty_o;
  logic                            full_o;

  modport slave (
    input  flush_i, alloc_valid_i, alloc_id_i, alloc_addr_i, alloc_rd_is_fp_i, alloc_we_i,
           rs_addr_i, rs_is_fp_i, cmpl_valid_i, cmpl_id_i,
    output alloc_ready_o, rs_busy_o, cmpl_hit_o, cmpl_addr_o, cmpl_rd_is_fp_o, cmpl_we_o,
           cmpl_err_o, count_o, empty_o, full_o
  );

  modport master (
    output flush_i, alloc_valid_i, alloc_id_i, alloc_addr_i, alloc_rd_is_fp_i, alloc_we_i,
           rs_addr_i, rs_is_fp_i, cmpl_valid_i, cmpl_id_i,
    input  alloc_ready_o, rs_busy_o, cmpl_hit_o, cmpl_addr_o, cmpl_rd_is_fp_o, cmpl_we_o,
           cmpl_err_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/fpu_ss_inflight_tracker.sv
// Associative table of outstanding FPU-subsystem instructions keyed by offload ID.
// Allocates into the lowest free slot, retires out of order, and flags RAW hazards per source.
module fpu_ss_inflight_entry #(
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned AddrWidth  = 5,
  parameter int unsigned NumRsPorts = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 wr_i,
  input  logic                                 clr_i,
  input  logic [IdWidth-1:0]                   wid_i,
  input  logic [AddrWidth-1:0]                 waddr_i,
  input  logic                                 wfp_i,
  input  logic                                 wwe_i,
  input  logic [IdWidth-1:0]                   alloc_id_i,
  input  logic [IdWidth-1:0]                   cmpl_id_i,
  input  logic [NumRsPorts-1:0][AddrWidth-1:0] rs_addr_i,
  input  logic [NumRsPorts-1:0]                rs_is_fp_i,
  output logic                                 alloc_match_o,
  output logic                                 cmpl_match_o,
  output logic [AddrWidth-1:0]                 addr_o,
  output logic                                 rd_is_fp_o,
  output logic                                 we_o,
  output logic                                 valid_o,
  output logic [NumRsPorts-1:0]                rs_hit_o
);
  logic                 valid_q;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 fp_q, we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      fp_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      if (flush_i)    valid_q <= 1'b0;
      else if (wr_i)  valid_q <= 1'b1;
      else if (clr_i) valid_q <= 1'b0;
      if (wr_i && !flush_i) begin
        id_q   <= wid_i;
        addr_q <= waddr_i;
        fp_q   <= wfp_i;
        we_q   <= wwe_i;
      end
    end
  end

  assign alloc_match_o = valid_q && (id_q == alloc_id_i);
  assign cmpl_match_o  = valid_q && (id_q == cmpl_id_i);
  assign addr_o        = addr_q;
  assign rd_is_fp_o    = fp_q;
  assign we_o          = we_q;
  assign valid_o       = valid_q;

  // Integer x0 is hardwired zero, so a pending write to it never blocks a reader.
  always_comb begin
    rs_hit_o = '0;
    for (int p = 0; p < NumRsPorts; p++)
      rs_hit_o[p] = valid_q && we_q && (fp_q == rs_is_fp_i[p]) && (addr_q == rs_addr_i[p]) &&
                    (rs_is_fp_i[p] || (rs_addr_i[p] != '0));
  end
endmodule

module fpu_ss_inflight_tracker #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned AddrWidth  = 5,
  parameter int unsigned NumRsPorts = 3
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  fpu_ss_inflight_tracker_if.slave bus
);
  localparam int unsigned CntW = $clog2(NumEntries + 1);

  logic [NumEntries-1:0]                 valid, amatch, cmatch, wr_oh, clr;
  logic [NumEntries-1:0][AddrWidth-1:0]  e_addr;
  logic [NumEntries-1:0]                 e_fp, e_we;
  logic [NumEntries-1:0][NumRsPorts-1:0] e_rs_hit;
  logic [NumRsPorts-1:0][AddrWidth-1:0]  rs_addr;
  logic [CntW-1:0]                       count_q, count_d;
  logic                                  full, id_conflict, alloc_fire, cmpl_match, cmpl_fire, found;

  assign rs_addr = bus.rs_addr_i;

  for (genvar e = 0; e < NumEntries; e++) begin : g_ent
    fpu_ss_inflight_entry #(
      .IdWidth(IdWidth), .AddrWidth(AddrWidth), .NumRsPorts(NumRsPorts)
    ) u_ent (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (bus.flush_i),
      .wr_i         (wr_oh[e]),
      .clr_i        (clr[e]),
      .wid_i        (bus.alloc_id_i),
      .waddr_i      (bus.alloc_addr_i),
      .wfp_i        (bus.alloc_rd_is_fp_i),
      .wwe_i        (bus.alloc_we_i),
      .alloc_id_i   (bus.alloc_id_i),
      .cmpl_id_i    (bus.cmpl_id_i),
      .rs_addr_i    (rs_addr),
      .rs_is_fp_i   (bus.rs_is_fp_i),
      .alloc_match_o(amatch[e]),
      .cmpl_match_o (cmatch[e]),
      .addr_o       (e_addr[e]),
      .rd_is_fp_o   (e_fp[e]),
      .we_o         (e_we[e]),
      .valid_o      (valid[e]),
      .rs_hit_o     (e_rs_hit[e])
    );
  end

  assign full        = (count_q == CntW'(NumEntries));
  assign id_conflict = |amatch;
  assign alloc_fire  = bus.alloc_valid_i && bus.alloc_ready_o;
  assign cmpl_match  = bus.cmpl_valid_i && (|cmatch);
  assign cmpl_fire   = cmpl_match && !bus.flush_i;
  assign clr         = cmatch & {NumEntries{cmpl_fire}};

  // Lowest-index free slot takes the new tag.
  always_comb begin
    wr_oh = '0;
    found = 1'b0;
    for (int e = 0; e < NumEntries; e++) begin
      if (!valid[e] && !found) begin
        wr_oh[e] = alloc_fire;
        found    = 1'b1;
      end
    end
  end

  // IDs are unique in the table, so OR-ing the selected entries is a clean mux.
  always_comb begin
    bus.cmpl_addr_o     = '0;
    bus.cmpl_rd_is_fp_o = 1'b0;
    bus.cmpl_we_o       = 1'b0;
    for (int e = 0; e < NumEntries; e++) begin
      if (bus.cmpl_valid_i && cmatch[e]) begin
        bus.cmpl_addr_o     = bus.cmpl_addr_o | e_addr[e];
        bus.cmpl_rd_is_fp_o = bus.cmpl_rd_is_fp_o | e_fp[e];
        bus.cmpl_we_o       = bus.cmpl_we_o | e_we[e];
      end
    end
  end

  always_comb begin
    bus.rs_busy_o = '0;
    for (int e = 0; e < NumEntries; e++) bus.rs_busy_o = bus.rs_busy_o | e_rs_hit[e];
  end

  assign bus.alloc_ready_o = !full && !id_conflict && !bus.flush_i;
  assign bus.cmpl_hit_o    = cmpl_match;
  assign bus.cmpl_err_o    = bus.cmpl_valid_i && !(|cmatch) && !bus.flush_i;
  assign bus.count_o       = count_q;
  assign bus.empty_o       = (count_q == '0);
  assign bus.full_o        = full;

  assign count_d = bus.flush_i ? '0 : count_q + CntW'(alloc_fire) - CntW'(cmpl_fire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end
endmodule
